// File: rtl/wb_pkg.sv
// Shared types and defaults for the posted-write buffer.
// Optional feature macro: WB_READ_FWD_EN (read forwarding from queued writes).
package wb_pkg;

   localparam int WB_DEPTH_DEF  = 4;
   localparam int WB_ADDR_W_DEF = 32;
   localparam int WB_DATA_W_DEF = 32;
   localparam int WB_PTR_W      = $clog2(WB_DEPTH_DEF);

   // Controller state, also exported on the top-level debug port.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2
   } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-buffer storage: circular FIFO of {addr,data} entries with head/tail
// pointers and an occupancy count. With WB_READ_FWD_EN defined it also
// compares every valid entry against cmp_addr and returns the youngest hit.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH  = WB_DEPTH_DEF,
   parameter int ADDR_W = WB_ADDR_W_DEF,
   parameter int DATA_W = WB_DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic              full,
   output logic              empty,
   input  logic [ADDR_W-1:0] cmp_addr,
   output logic              fwd_hit,
   output logic [DATA_W-1:0] fwd_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  head_q;
   logic [PTR_W-1:0]  tail_q;
   logic [CNT_W-1:0]  count_q;

   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign head_addr = addr_q[head_q];
   assign head_data = data_q[head_q];

   // Entry storage, written at the tail on every accepted push.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= push_addr;
         data_q[tail_q] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; a push and a
   // pop on the same edge leave the count unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) tail_q <= tail_q + PTR_W'(1);
         if (pop)  head_q <= head_q + PTR_W'(1);
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

`ifdef WB_READ_FWD_EN
   logic [DEPTH-1:0] match_vec;
   logic [PTR_W-1:0] offset [DEPTH];
   logic [PTR_W-1:0] fwd_idx;

   // An entry matches when it holds cmp_addr and sits between head and tail.
   always_comb begin
      match_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset[i]    = PTR_W'(i) - head_q;
         match_vec[i] = (addr_q[i] == cmp_addr) && ({1'b0, offset[i]} < count_q);
      end
   end

   // Walk oldest to youngest so the last (youngest) match wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = head_q;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = head_q + PTR_W'(k);
         if (match_vec[fwd_idx]) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[fwd_idx];
         end
      end
   end
`else
   logic unused_cmp;
   assign unused_cmp = ^cmp_addr;
   assign fwd_hit    = 1'b0;
   assign fwd_data   = '0;
`endif

endmodule

// File: rtl/write_buffer.sv
// Posted-write buffer between the data cache and the cache controller.
// Writes are queued and drained to memory when it is otherwise idle; reads
// bypass the queue (WB_READ_FWD_EN defined: forwarded from the youngest
// matching entry, else sent to memory) or wait for the queue to empty
// (WB_READ_FWD_EN undefined: strict ordering).
//
// Handshakes:
//   dc side : dc_write is a one-cycle push, accepted when dc_wr_rdy=1 in the
//             same cycle. dc_read (with dc_addr) is held until the cycle in
//             which dc_rd_done pulses; dc_rdata is valid in that cycle.
//   mem side: mem_read/mem_write with mem_addr/mem_wdata are held stable
//             until the one-cycle mem_ready pulse; the request then drops
//             and at least one IDLE cycle separates transactions.
module write_buffer
   import wb_pkg::*;
#(
   parameter int DEPTH  = WB_DEPTH_DEF,
   parameter int ADDR_W = WB_ADDR_W_DEF,
   parameter int DATA_W = WB_DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dc_write,
   output logic              dc_wr_rdy,
   input  logic              dc_read,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic [DATA_W-1:0] dc_rdata,
   output logic              dc_rd_done,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              wb_empty,
   output wb_state_t         dbg_state
);

   wb_state_t         state_q;
   wb_state_t         state_d;
   logic              rd_issue;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [DATA_W-1:0] dc_rdata_q;
   logic              dc_rd_done_q;

   logic              fifo_full;
   logic              fifo_empty;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;

   logic              push;
   logic              pop;
   logic              rd_pending;
   logic              rd_mem_done;
   logic              fwd_take;

   // A full buffer still takes a push on the edge that retires the head.
   assign pop         = (state_q == WR_WAIT) && mem_ready;
   assign dc_wr_rdy   = !fifo_full || pop;
   assign push        = dc_write && dc_wr_rdy;

   // dc_read stays high through the dc_rd_done cycle; that cycle is not a new request.
   assign rd_pending  = dc_read && !dc_rd_done_q;
   assign rd_mem_done = (state_q == RD_WAIT) && mem_ready;
   assign fwd_take    = rd_pending && fwd_hit && (state_q != RD_WAIT);

   wb_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_addr (dc_addr),
      .push_data (dc_wdata),
      .pop       (pop),
      .head_addr (head_addr),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .cmp_addr  (dc_addr),
      .fwd_hit   (fwd_hit),
      .fwd_data  (fwd_data)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state: choose between issuing a read and draining the head in IDLE.
   always_comb begin
      state_d  = state_q;
      rd_issue = 1'b0;
      unique case (state_q)
         IDLE: begin
`ifdef WB_READ_FWD_EN
            // Reads go first unless the buffer is full; forwarded reads need no memory.
            if (rd_pending && !fwd_hit && !fifo_full) begin
               state_d  = RD_WAIT;
               rd_issue = 1'b1;
            end else if (!fifo_empty) begin
               state_d  = WR_WAIT;
            end
`else
            // Reads are held until every older write has reached memory.
            if (!fifo_empty) begin
               state_d  = WR_WAIT;
            end else if (rd_pending) begin
               state_d  = RD_WAIT;
               rd_issue = 1'b1;
            end
`endif
         end
         RD_WAIT: if (mem_ready) state_d = IDLE;
         WR_WAIT: if (mem_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Memory-side outputs follow the state; the read address is captured at
   // issue so it cannot move while mem_read is held.
   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (state_q)
         RD_WAIT: begin
            mem_read = 1'b1;
            mem_addr = rd_addr_q;
         end
         WR_WAIT: begin
            mem_write = 1'b1;
            mem_addr  = head_addr;
            mem_wdata = head_data;
         end
         default: ;
      endcase
   end

   // Read return path: capture data and pulse done the cycle after completion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_addr_q    <= '0;
         dc_rdata_q   <= '0;
         dc_rd_done_q <= 1'b0;
      end else begin
         dc_rd_done_q <= rd_mem_done || fwd_take;
         if (rd_mem_done)   dc_rdata_q <= mem_rdata;
         else if (fwd_take) dc_rdata_q <= fwd_data;
         if (rd_issue)      rd_addr_q  <= dc_addr;
      end
   end

   assign dc_rdata   = dc_rdata_q;
   assign dc_rd_done = dc_rd_done_q;
   assign wb_empty   = fifo_empty && (state_q == IDLE);
   assign dbg_state  = state_q;

endmodule
